// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter. The grant is presented in 2x4-decoder form:
// index {A,B}, active-low enable E, and the decoded active-low one-hot lines D.
`timescale 1ns/1ps

module rr_decoder_arbiter #(
    parameter int HOLD_MAX = 8   // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:3] R,
    output logic [0:3] D,
    output logic       A,
    output logic       B,
    output logic       E,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       a_q,     a_d;
    logic       b_q,     b_d;
    logic       e_q,     e_d;
    logic       busy_q,  busy_d;
    logic [0:3] d_q,     d_d;

    logic [1:0] grant_idx;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic [1:0] cand;

    assign grant_idx = {a_q, b_q};

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch; otherwise an
        // unassigned path would infer a latch.
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (R[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        e_d     = e_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    {a_d, b_d} = pick_idx;
                    e_d        = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = 8'd0;
                end
            end
            GRANT: begin
                if (!R[grant_idx] || (cnt_q == CNT_LAST)) begin
                    // Release: A,B keep the last index; ptr moves past the holder.
                    state_d = IDLE;
                    e_d     = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                    ptr_d   = grant_idx + 2'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // D is decoded from the next-state index/enable so it registers in step with them.
        d_d = 4'b1111;
        if (!e_d) begin
            d_d[{a_d, b_d}] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            e_q     <= 1'b1;
            busy_q  <= 1'b0;
            d_q     <= 4'b1111;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            d_q     <= d_d;
        end
    end

    assign D    = d_q;
    assign A    = a_q;
    assign B    = b_q;
    assign E    = e_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: a directed vector table plus
// hand-written multi-cycle sequences on three instances (HOLD_MAX = 8, 4, 1).
`timescale 1ns/1ps

module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:3] R;

    logic [0:3] d8, d4, d1;
    logic       a8, b8, e8, busy8;
    logic       a4, b4, e4, busy4;
    logic       a1, b1, e1, busy1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.HOLD_MAX(8)) dut8 (
        .clk(clk), .rst(rst), .R(R), .D(d8), .A(a8), .B(b8), .E(e8), .busy(busy8)
    );
    rr_decoder_arbiter #(.HOLD_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .R(R), .D(d4), .A(a4), .B(b4), .E(e4), .busy(busy4)
    );
    rr_decoder_arbiter #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .R(R), .D(d1), .A(a1), .B(b1), .E(e1), .busy(busy1)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [0:3] r;
        logic [7:0] exp;   // {D[0:3], A, B, E, busy}
    } vec_t;

    vec_t vecs[$];

    // Observed outputs packed as {D[0:3], A, B, E, busy}; 0=HOLD_MAX 8, 1=4, 2=1.
    function automatic logic [7:0] obs(input int which);
        case (which)
            0:       return {d8, a8, b8, e8, busy8};
            1:       return {d4, a4, b4, e4, busy4};
            default: return {d1, a1, b1, e1, busy1};
        endcase
    endfunction

    function automatic logic [0:3] dec(input logic [1:0] g);
        logic [0:3] d;
        d    = 4'b1111;
        d[g] = 1'b0;
        return d;
    endfunction

    function automatic logic [7:0] granted(input logic [1:0] g);
        return {dec(g), g, 1'b0, 1'b1};
    endfunction

    function automatic logic [7:0] idle_exp(input logic [1:0] g);
        return {4'b1111, g, 1'b1, 1'b0};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input logic r_st, input logic [0:3] r,
                           input logic [7:0] exp);
        vec_t v;
        v.name = name;
        v.rst  = r_st;
        v.r    = r;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        R   = 4'b0000;
        cycle();
        rst = 1'b0;
    endtask

    task automatic hold_cycles(input int which, input int n, input logic [1:0] g, input string tag);
        for (int c = 0; c < n; c++) begin
            cycle();
            check(tag, obs(which), granted(g));
        end
    endtask

    task automatic dead(input int which, input logic [1:0] g, input string tag);
        cycle();
        check({tag, "_dead"}, obs(which), idle_exp(g));
    endtask

    task automatic expect_grant(input int which, input int hold, input logic [1:0] g, input string tag);
        hold_cycles(which, hold, g, tag);
        dead(which, g, tag);
    endtask

    // Decoder invariant, one-hot D, busy/E agreement and break-before-make on every instance.
    logic       prev_e [3] = '{1'b1, 1'b1, 1'b1};
    logic [1:0] prev_ab[3] = '{2'b00, 2'b00, 2'b00};

    task automatic monitor(input int w);
        logic [7:0] o;
        logic [0:3] d;
        logic [1:0] ab;
        logic       e;
        logic       ok;
        o  = obs(w);
        d  = o[7:4];
        ab = o[3:2];
        e  = o[1];
        check("mon_decode", {4'h0, d}, {4'h0, (e ? 4'b1111 : dec(ab))});
        ok = ($countones(~d) <= 1);
        check("mon_onehot", {7'd0, ok}, 8'd1);
        check("mon_busy_e", {7'd0, o[0]}, {7'd0, ~e});
        if (!prev_e[w] && !e) begin
            check("mon_break_before_make", {6'd0, ab}, {6'd0, prev_ab[w]});
        end
        prev_e[w]  = e;
        prev_ab[w] = ab;
    endtask

    always @(negedge clk) begin
        for (int w = 0; w < 3; w++) monitor(w);
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        R   = 4'b1111;

        add_vec("reset_assert",     1'b1, 4'b1111, idle_exp(2'd0));
        add_vec("reset_hold",       1'b1, 4'b1111, idle_exp(2'd0));
        add_vec("idle_no_req",      1'b0, 4'b0000, idle_exp(2'd0));
        add_vec("single_grant",     1'b0, 4'b0100, granted(2'd1));
        add_vec("single_hold1",     1'b0, 4'b0100, granted(2'd1));
        add_vec("single_hold2",     1'b0, 4'b0100, granted(2'd1));
        add_vec("single_release",   1'b0, 4'b0000, idle_exp(2'd1));
        add_vec("idle_keeps_ab",    1'b0, 4'b0000, idle_exp(2'd1));
        add_vec("rr_from_ptr2",     1'b0, 4'b1100, granted(2'd0));
        add_vec("release0",         1'b0, 4'b0100, idle_exp(2'd0));
        add_vec("rr_from_ptr1",     1'b0, 4'b0101, granted(2'd1));
        add_vec("release1",         1'b0, 4'b0001, idle_exp(2'd1));
        add_vec("grant3",           1'b0, 4'b0001, granted(2'd3));
        add_vec("ignore_other_req", 1'b0, 4'b0101, granted(2'd3));
        add_vec("release3",         1'b0, 4'b0100, idle_exp(2'd3));
        add_vec("ptr_wraps_to0",    1'b0, 4'b1001, granted(2'd0));
        add_vec("release_wrap",     1'b0, 4'b0000, idle_exp(2'd0));
        add_vec("reset_again",      1'b1, 4'b0000, idle_exp(2'd0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            R   = vecs[i].r;
            cycle();
            check(vecs[i].name, obs(0), vecs[i].exp);
        end

        // Forced rotation with HOLD_MAX=8: 0,1,2,3,0, each 8 cycles plus one dead cycle.
        do_reset();
        R = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            expect_grant(0, 8, 2'(g), "rotate8");
        end

        // Fairness with HOLD_MAX=4: 0,3,0,3 then R[1] joins during grant 3 -> 0,1,3.
        do_reset();
        R = 4'b1001;
        expect_grant(1, 4, 2'd0, "fair_a0");
        expect_grant(1, 4, 2'd3, "fair_a3");
        expect_grant(1, 4, 2'd0, "fair_b0");
        hold_cycles(1, 1, 2'd3, "fair_b3");
        R = 4'b1101;
        hold_cycles(1, 3, 2'd3, "fair_b3");
        dead(1, 2'd3, "fair_b3");
        expect_grant(1, 4, 2'd0, "fair_c0");
        expect_grant(1, 4, 2'd1, "fair_c1");
        expect_grant(1, 4, 2'd3, "fair_c3");

        // HOLD_MAX=1: one-cycle grants separated by a dead cycle.
        do_reset();
        R = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            expect_grant(2, 1, 2'(g), "hold1");
        end

        // Async reset mid-grant, then arbitration restarts from ptr=0.
        do_reset();
        R = 4'b0010;
        cycle();
        check("ar_grant2", obs(0), granted(2'd2));
        R = 4'b0000;
        cycle();
        check("ar_release2", obs(0), idle_exp(2'd2));
        R = 4'b0010;
        cycle();
        check("ar_regrant2", obs(0), granted(2'd2));
        #1 rst = 1'b1;
        #1 check("ar_async_clear", obs(0), idle_exp(2'd0));
        #1 rst = 1'b0;
        R = 4'b0011;
        cycle();
        check("ar_restart_ptr0", obs(0), granted(2'd2));
        cycle();
        check("ar_restart_hold", obs(0), granted(2'd2));
        R = 4'b0000;
        cycle();
        check("ar_final_release", obs(0), idle_exp(2'd2));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Four-requester round-robin arbiter that shares a single resource.
- Grant is issued in 2x4-decoder form: index A,B plus active-low enable E, and decoded active-low one-hot lines D[0:3].
- Intended to sit in front of the existing 2x4 decoder stage: A,B,E feed a decoder directly, or D drives resource selects.
- Adds hold-time limiting and one dead cycle between grants (break-before-make).

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles a single grant may be held. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- R  input  [0:3]  request lines, active-high; R[i] is requester i.
- D  output  [0:3]  grant lines, active-low one-hot; D[i]=0 means requester i is granted.
- A  output  1  grant index MSB (index = {A,B}).
- B  output  1  grant index LSB.
- E  output  1  active-low grant enable; 0 while any grant is active.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset values (rst=1, effective immediately, no clock needed):
  - state=IDLE, ptr=0, cnt=0.
  - D=4'b1111, A=0, B=0, E=1, busy=0.
- All outputs are registered. Combinational R-to-output paths are forbidden.
- Invariant checked every cycle:
  - D[0] = !(!A & !B & !E)
  - D[1] = !(!A & B & !E)
  - D[2] = !(A & !B & !E)
  - D[3] = !(A & B & !E)
  - At most one D bit is low. E=1 implies D=1111.
- States: IDLE and GRANT.
- IDLE:
  - If R==0: stay in IDLE; outputs hold reset-like values, A/B unchanged.
  - Otherwise, on the edge: select the first asserted R[i] scanning i = ptr, ptr+1, ... mod 4.
  - Load {A,B}=i, E=0, D[i]=0, cnt=0, busy=1; go to GRANT.
  - Latency: grant is visible 1 cycle after R is first sampled high.
- GRANT, evaluated at each edge with idx={A,B}:
  - If R[idx]==0 (voluntary release) or cnt==HOLD_MAX-1 (forced release):
    - Go to IDLE with E=1, D=1111, busy=0.
    - Set ptr=(idx+1) mod 4 (2-bit wrap: 3 -> 0).
    - Keep A,B at their last value.
  - Otherwise: cnt=cnt+1 and the grant is held.
  - cnt is 8 bits wide and never exceeds HOLD_MAX-1.
- A grant therefore lasts min(cycles until R[idx] is sampled low, HOLD_MAX) cycles. It drops one cycle after the requester deasserts.
- Every release is followed by at least one IDLE cycle with D=1111. Back-to-back grants never overlap or abut.
- A force-released requester that keeps R high becomes lowest priority (ptr has advanced past it). It is re-granted only after the other pending requesters are served.
- Requests from non-granted requesters during GRANT are ignored until IDLE. There is no queueing beyond the live R level.
- HOLD_MAX=1: each grant lasts exactly one cycle, with a dead cycle between grants.
- Reset asserted mid-GRANT: D returns to 1111 and E to 1 asynchronously. After rst deasserts, arbitration restarts from ptr=0.

Test Plan:
- Reset: rst=1 with R=1111 -> D=1111, E=1, A=0, B=0, busy=0; unchanged across clock edges while rst is held.
- Single request: R=0100 from edge 1 and held 3 cycles, then 0000 -> from edge 2 D=1011, A=0, B=1, E=0. D=1111 on the edge after R[1] is sampled low.
- Forced rotation (HOLD_MAX=8), R=1111 held -> grant sequence 0,1,2,3,0. Each grant lasts 8 cycles followed by 1 dead cycle (9-cycle period); each D pattern appears once per rotation.
- Fairness: R=1001 held, HOLD_MAX=4 -> grants alternate 0,3,0,3. Then add R[1]=1 during grant 3 -> next grants are 0,1,3.
- Async reset mid-grant: during grant 2 (D=1101), pulse rst high between edges -> D=1111, E=1 immediately. After release with R=0010, D=1101 one cycle later.
- Invariant monitor over all scenarios: D always equals the decoder function of (A,B,E); never two D bits low; D=1111 for at least 1 cycle between any two different grants.
